// File: rtl/compressor_count_accum_pkg.sv
// Shared constants, S3 state type and beat-weighting helper for the
// compressor count accumulator.
package compressor_count_accum_pkg;

   localparam int unsigned DATA_W = 152;

   localparam int unsigned W1_LO = 0;
   localparam int unsigned W1_W  = 19;
   localparam int unsigned W2_LO = 19;
   localparam int unsigned W2_W  = 57;
   localparam int unsigned W4_LO = 76;
   localparam int unsigned W4_W  = 57;
   localparam int unsigned W8_LO = 133;
   localparam int unsigned W8_W  = 19;

   localparam int unsigned PC1_W = 5;
   localparam int unsigned PC2_W = 6;
   localparam int unsigned PC4_W = 6;
   localparam int unsigned PC8_W = 5;

   localparam int unsigned BEAT_SUM_W   = 10;
   localparam int unsigned BEAT_SUM_MAX = 513;

   typedef enum logic {
      StIdle,
      StOpen
   } acc_state_e;

   function automatic logic [BEAT_SUM_W-1:0] weigh_groups(
      input logic [PC1_W-1:0] pc1,
      input logic [PC2_W-1:0] pc2,
      input logic [PC4_W-1:0] pc4,
      input logic [PC8_W-1:0] pc8
   );
      return BEAT_SUM_W'(pc1) + BEAT_SUM_W'({pc2, 1'b0}) +
             BEAT_SUM_W'({pc4, 2'b00}) + BEAT_SUM_W'({pc8, 3'b000});
   endfunction

endpackage

// File: rtl/compressor_count_accum_if.sv
// Beat input and frame-result output handshakes of the count accumulator.
// master is the surrounding datapath, slave is the accumulator itself.
interface compressor_count_accum_if
   import compressor_count_accum_pkg::*;
#(
   parameter int unsigned ACC_W = 16,
   parameter int unsigned CNT_W = 8
) ();

   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_data;
   logic              s_last;
   logic              m_valid;
   logic              m_ready;
   logic [ACC_W-1:0]  m_sum;
   logic [CNT_W-1:0]  m_beats;
   logic              m_ovf;

   modport master (
      output s_valid, s_data, s_last, m_ready,
      input  s_ready, m_valid, m_sum, m_beats, m_ovf
   );

   modport slave (
      input  s_valid, s_data, s_last, m_ready,
      output s_ready, m_valid, m_sum, m_beats, m_ovf
   );

endinterface

// File: rtl/compressor_count_accum_group_popcount_152.sv
// Combinational popcount of the four weight groups of a 152-bit compressor
// output vector.
module group_popcount_152
   import compressor_count_accum_pkg::*;
(
   input  logic [DATA_W-1:0] data,
   output logic [PC1_W-1:0]  pc_w1,
   output logic [PC2_W-1:0]  pc_w2,
   output logic [PC4_W-1:0]  pc_w4,
   output logic [PC8_W-1:0]  pc_w8
);

   always_comb begin
      pc_w1 = '0;
      pc_w2 = '0;
      pc_w4 = '0;
      pc_w8 = '0;
      for (int i = 0; i < W1_W; i++) pc_w1 = pc_w1 + PC1_W'(data[W1_LO + i]);
      for (int i = 0; i < W2_W; i++) pc_w2 = pc_w2 + PC2_W'(data[W2_LO + i]);
      for (int i = 0; i < W4_W; i++) pc_w4 = pc_w4 + PC4_W'(data[W4_LO + i]);
      for (int i = 0; i < W8_W; i++) pc_w8 = pc_w8 + PC8_W'(data[W8_LO + i]);
   end

endmodule

// File: rtl/compressor_count_accum.sv
// Three-stage beat counter: S1 group popcounts, S2 weighted beat sum, S3
// saturating per-frame accumulator feeding a one-deep result register.
module compressor_count_accum
   import compressor_count_accum_pkg::*;
#(
   parameter int unsigned ACC_W = 16,
   parameter int unsigned CNT_W = 8
) (
   input logic                     clk,
   input logic                     rst_n,
   compressor_count_accum_if.slave bus
);

   logic en;

   logic [PC1_W-1:0] pc_w1;
   logic [PC2_W-1:0] pc_w2;
   logic [PC4_W-1:0] pc_w4;
   logic [PC8_W-1:0] pc_w8;

   logic             s1_valid_q, s1_last_q;
   logic [PC1_W-1:0] s1_pc1_q;
   logic [PC2_W-1:0] s1_pc2_q;
   logic [PC4_W-1:0] s1_pc4_q;
   logic [PC8_W-1:0] s1_pc8_q;

   logic                  s2_valid_q, s2_last_q;
   logic [BEAT_SUM_W-1:0] s2_sum_q;

   acc_state_e       state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] beats_q, beats_d;
   logic             ovf_q, ovf_d;

   logic             res_valid_q, res_valid_d;
   logic [ACC_W-1:0] res_sum_q, res_sum_d;
   logic [CNT_W-1:0] res_beats_q, res_beats_d;
   logic             res_ovf_q, res_ovf_d;

   logic [ACC_W-1:0] base_acc, acc_next;
   logic [CNT_W-1:0] base_beats, beats_next;
   logic             base_ovf, ovf_next, acc_sat, beats_sat;
   logic [ACC_W:0]   sum_ext;

   // One enable stalls the whole pipe so no beat slips past a held result.
   assign en          = !res_valid_q || bus.m_ready;
   assign bus.s_ready = en;
   assign bus.m_valid = res_valid_q;
   assign bus.m_sum   = res_sum_q;
   assign bus.m_beats = res_beats_q;
   assign bus.m_ovf   = res_ovf_q;

   group_popcount_152 u_popcount (
      .data  (bus.s_data),
      .pc_w1 (pc_w1),
      .pc_w2 (pc_w2),
      .pc_w4 (pc_w4),
      .pc_w8 (pc_w8)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_pc1_q   <= '0;
         s1_pc2_q   <= '0;
         s1_pc4_q   <= '0;
         s1_pc8_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_last_q  <= 1'b0;
         s2_sum_q   <= '0;
      end else if (en) begin
         s1_valid_q <= bus.s_valid;
         s1_last_q  <= bus.s_valid && bus.s_last;
         s1_pc1_q   <= pc_w1;
         s1_pc2_q   <= pc_w2;
         s1_pc4_q   <= pc_w4;
         s1_pc8_q   <= pc_w8;
         s2_valid_q <= s1_valid_q;
         s2_last_q  <= s1_last_q;
         s2_sum_q   <= weigh_groups(s1_pc1_q, s1_pc2_q, s1_pc4_q, s1_pc8_q);
      end
   end

   always_comb begin
      // An idle accumulator behaves as if it held zero, so the first beat loads.
      base_acc   = (state_q == StOpen) ? acc_q : '0;
      base_beats = (state_q == StOpen) ? beats_q : '0;
      base_ovf   = (state_q == StOpen) ? ovf_q : 1'b0;
      sum_ext    = {1'b0, base_acc} + (ACC_W + 1)'(s2_sum_q);
      acc_sat    = sum_ext[ACC_W];
      acc_next   = acc_sat ? '1 : sum_ext[ACC_W-1:0];
      beats_sat  = &base_beats;
      beats_next = beats_sat ? base_beats : base_beats + CNT_W'(1);
      ovf_next   = base_ovf | acc_sat | beats_sat;

      state_d     = state_q;
      acc_d       = acc_q;
      beats_d     = beats_q;
      ovf_d       = ovf_q;
      res_valid_d = res_valid_q;
      res_sum_d   = res_sum_q;
      res_beats_d = res_beats_q;
      res_ovf_d   = res_ovf_q;

      if (en) begin
         res_valid_d = s2_valid_q && s2_last_q;
         if (s2_valid_q) begin
            if (s2_last_q) begin
               res_sum_d   = acc_next;
               res_beats_d = beats_next;
               res_ovf_d   = ovf_next;
               state_d     = StIdle;
               acc_d       = '0;
               beats_d     = '0;
               ovf_d       = 1'b0;
            end else begin
               state_d = StOpen;
               acc_d   = acc_next;
               beats_d = beats_next;
               ovf_d   = ovf_next;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         acc_q       <= '0;
         beats_q     <= '0;
         ovf_q       <= 1'b0;
         res_valid_q <= 1'b0;
         res_sum_q   <= '0;
         res_beats_q <= '0;
         res_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         beats_q     <= beats_d;
         ovf_q       <= ovf_d;
         res_valid_q <= res_valid_d;
         res_sum_q   <= res_sum_d;
         res_beats_q <= res_beats_d;
         res_ovf_q   <= res_ovf_d;
      end
   end

endmodule

// File: tb/tb_compressor_count_accum.sv
// Directed bench for compressor_count_accum: latency, saturation, stall,
// mid-frame reset and back-to-back frame results.
module tb_compressor_count_accum;
   import compressor_count_accum_pkg::*;

   localparam int unsigned ACC_W = 16;
   localparam int unsigned CNT_W = 8;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   compressor_count_accum_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

   compressor_count_accum #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] make_beat(input int n1, input int n2, input int n4,
                                                  input int n8);
      logic [DATA_W-1:0] d;
      d = '0;
      for (int i = 0; i < n1; i++) d[W1_LO + i] = 1'b1;
      for (int i = 0; i < n2; i++) d[W2_LO + i] = 1'b1;
      for (int i = 0; i < n4; i++) d[W4_LO + i] = 1'b1;
      for (int i = 0; i < n8; i++) d[W8_LO + i] = 1'b1;
      return d;
   endfunction

   // Holds the beat until a clock edge sees s_valid && s_ready.
   task automatic send_beat(input logic [DATA_W-1:0] d, input logic last);
      int n;
      bit accepted;
      n = 0;
      accepted = 1'b0;
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      bus.s_last  = last;
      while (!accepted && n < 100) begin
         @(negedge clk);
         accepted = bus.s_ready;
         tick();
         n++;
      end
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.s_last  = 1'b0;
      if (!accepted) chk("send_accept", 32'(accepted), 32'd1);
   endtask

   // Idle cycles carry garbage data/last that must be ignored.
   task automatic idle(input int n);
      bus.s_valid = 1'b0;
      bus.s_data  = '1;
      bus.s_last  = 1'b1;
      for (int i = 0; i < n; i++) tick();
      bus.s_data  = '0;
      bus.s_last  = 1'b0;
   endtask

   task automatic wait_result(input string tag, input int es, input int eb, input int eo);
      int n;
      n = 0;
      while (bus.m_valid !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk({tag, "_valid"}, 32'(bus.m_valid), 32'd1);
      chk({tag, "_sum"}, 32'(bus.m_sum), 32'(es));
      chk({tag, "_beats"}, 32'(bus.m_beats), 32'(eb));
      chk({tag, "_ovf"}, 32'(bus.m_ovf), 32'(eo));
      tick();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n       = 1'b0;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.s_last  = 1'b0;
      bus.m_ready = 1'b1;

      #12;
      chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
      chk("rst_m_sum", 32'(bus.m_sum), 32'd0);
      chk("rst_m_beats", 32'(bus.m_beats), 32'd0);
      chk("rst_m_ovf", 32'(bus.m_ovf), 32'd0);
      chk("rst_s_ready", 32'(bus.s_ready), 32'd1);
      rst_n = 1'b1;
      tick();

      // Single all-ones beat: two-edge latency to m_valid.
      send_beat('1, 1'b1);
      chk("lat_e0_valid", 32'(bus.m_valid), 32'd0);
      tick();
      chk("lat_e1_valid", 32'(bus.m_valid), 32'd0);
      tick();
      chk("lat_e2_valid", 32'(bus.m_valid), 32'd1);
      wait_result("ones", BEAT_SUM_MAX, 1, 0);
      chk("ones_drained", 32'(bus.m_valid), 32'd0);

      // One bit per weight 1, 2 and 8 group.
      send_beat(make_beat(1, 0, 0, 0), 1'b0);
      send_beat(make_beat(0, 1, 0, 0), 1'b0);
      send_beat(make_beat(0, 0, 0, 1), 1'b1);
      wait_result("onehot", 11, 3, 0);

      for (int i = 0; i < 128; i++) send_beat('1, 1'(i == 127));
      wait_result("sat128", 65535, 128, 1);
      for (int i = 0; i < 127; i++) send_beat('1, 1'(i == 126));
      wait_result("nosat127", 65151, 127, 0);

      for (int i = 0; i < 256; i++) send_beat('0, 1'(i == 255));
      wait_result("beatsat", 0, 255, 1);

      // Gaps with garbage on the bus, and m_ready low with nothing pending.
      send_beat(make_beat(5, 0, 0, 0), 1'b0);
      idle(2);
      send_beat(make_beat(1, 0, 0, 1), 1'b0);
      bus.m_ready = 1'b0;
      #1;
      chk("gap_s_ready", 32'(bus.s_ready), 32'd1);
      idle(2);
      send_beat(make_beat(0, 2, 4, 0), 1'b1);
      bus.m_ready = 1'b1;
      wait_result("gaps", 34, 3, 0);

      // Output drain and next last beat on the same edge.
      send_beat(make_beat(1, 0, 0, 0), 1'b1);
      send_beat(make_beat(0, 1, 0, 0), 1'b1);
      tick();
      chk("b2b_first_valid", 32'(bus.m_valid), 32'd1);
      chk("b2b_first_sum", 32'(bus.m_sum), 32'd1);
      tick();
      chk("b2b_second_valid", 32'(bus.m_valid), 32'd1);
      chk("b2b_second_sum", 32'(bus.m_sum), 32'd2);
      chk("b2b_second_beats", 32'(bus.m_beats), 32'd1);
      tick();
      chk("b2b_drained", 32'(bus.m_valid), 32'd0);

      // Downstream stall while a second frame is in flight.
      bus.m_ready = 1'b0;
      send_beat('1, 1'b1);
      send_beat(make_beat(2, 0, 0, 0), 1'b0);
      send_beat(make_beat(0, 1, 0, 0), 1'b1);
      for (int i = 0; i < 5; i++) begin
         chk("stall_s_ready", 32'(bus.s_ready), 32'd0);
         chk("stall_valid", 32'(bus.m_valid), 32'd1);
         chk("stall_sum", 32'(bus.m_sum), 32'd513);
         chk("stall_beats", 32'(bus.m_beats), 32'd1);
         tick();
      end
      bus.m_ready = 1'b1;
      tick();
      chk("stall_released", 32'(bus.m_valid), 32'd0);
      wait_result("stall_second", 4, 2, 0);

      // Reset with one beat in S3 and one still in the pipe.
      send_beat(make_beat(0, 0, 1, 12), 1'b0);
      send_beat(make_beat(0, 0, 1, 12), 1'b0);
      tick();
      rst_n = 1'b0;
      #2;
      chk("midrst_valid", 32'(bus.m_valid), 32'd0);
      chk("midrst_s_ready", 32'(bus.s_ready), 32'd1);
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("postrst_quiet", 32'(bus.m_valid), 32'd0);
      end
      send_beat(make_beat(1, 1, 1, 0), 1'b1);
      wait_result("postrst", 7, 1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
